// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic ops, shift-add multiply and restoring divide, one bit per clock.
// Optional flag logic is compiled in when SEQ_ALU_FLAGS_EN is defined; otherwise flags reads 4'b0000.
module seq_alu #(
  parameter  int DATA_WIDTH = 16,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            oc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] f,
  output logic [DATA_WIDTH-1:0] rem,
  output logic [3:0]            flags,
  output logic                  div_zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    state, state_nx;
  logic [CNT_WIDTH-1:0]      cnt;
  logic                      accept;
  logic                      last_iter;

  // Iterative datapath state (no reset: only meaningful after an accepted op)
  logic [DATA_WIDTH-1:0]     opa_r;
  logic [DATA_WIDTH-1:0]     opb_r;
  logic [2*DATA_WIDTH-1:0]   acc_r;
  logic [DATA_WIDTH-1:0]     part_r;
  logic [DATA_WIDTH-1:0]     quot_r;

  logic [DATA_WIDTH:0]       mul_sum;
  logic [2*DATA_WIDTH-1:0]   acc_nx;
  logic [DATA_WIDTH:0]       trial;
  logic [DATA_WIDTH-1:0]     part_nx;
  logic [DATA_WIDTH-1:0]     quot_nx;

  logic [DATA_WIDTH-1:0]     add_w;
  logic [DATA_WIDTH-1:0]     sub_w;

  logic                      res_ld;
  logic [DATA_WIDTH-1:0]     res_f;
  logic [DATA_WIDTH-1:0]     res_rem;
  logic                      res_dz;

`ifdef SEQ_ALU_FLAGS_EN
  logic                      res_c;
  logic                      res_v;
  logic [3:0]                flags_r;

  function automatic logic [3:0] pack_flags(input logic [DATA_WIDTH-1:0] r,
                                            input logic c,
                                            input logic v);
    return {(r == '0), r[DATA_WIDTH-1], c, v};
  endfunction
`endif

  assign accept    = start && (state == S_IDLE);
  assign last_iter = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));
  assign ready     = (state == S_IDLE);
  assign done      = (state == S_DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (oc == OP_MUL)                   state_nx = S_MUL;
          else if (oc == OP_DIV && b != '0)   state_nx = S_DIV;
          else                                state_nx = S_DONE;
        end
      end
      S_MUL:   if (last_iter) state_nx = S_DONE;
      S_DIV:   if (last_iter) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Shift-add multiply step: conditionally add A into the high half, then shift the whole accumulator right
  always_comb begin
    mul_sum = {1'b0, acc_r[2*DATA_WIDTH-1:DATA_WIDTH]} +
              (acc_r[0] ? {1'b0, opa_r} : {(DATA_WIDTH+1){1'b0}});
    acc_nx  = {mul_sum, acc_r[DATA_WIDTH-1:1]};
  end

  // Restoring divide step: the partial remainder stays below the divisor, so it fits in DATA_WIDTH bits
  always_comb begin
    trial = {part_r, quot_r[DATA_WIDTH-1]} - {1'b0, opb_r};
    if (!trial[DATA_WIDTH]) begin
      part_nx = trial[DATA_WIDTH-1:0];
      quot_nx = {quot_r[DATA_WIDTH-2:0], 1'b1};
    end else begin
      part_nx = {part_r[DATA_WIDTH-2:0], quot_r[DATA_WIDTH-1]};
      quot_nx = {quot_r[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Result selection for whichever edge raises done
  always_comb begin
    add_w   = a + b;
    sub_w   = a - b;
    res_ld  = 1'b0;
    res_f   = '0;
    res_rem = '0;
    res_dz  = 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
    res_c   = 1'b0;
    res_v   = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          unique case (oc)
            OP_ADD: begin
              res_ld = 1'b1;
              res_f  = add_w;
`ifdef SEQ_ALU_FLAGS_EN
              res_c  = (add_w < a);
              res_v  = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                       (add_w[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
`endif
            end
            OP_SUB: begin
              res_ld = 1'b1;
              res_f  = sub_w;
`ifdef SEQ_ALU_FLAGS_EN
              res_c  = (a < b);
              res_v  = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                       (sub_w[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
`endif
            end
            OP_MUL: res_ld = 1'b0;
            OP_DIV: begin
              if (b == '0) begin
                res_ld  = 1'b1;
                res_f   = '1;
                res_rem = a;
                res_dz  = 1'b1;
              end
            end
            OP_NOT: begin
              res_ld = 1'b1;
              res_f  = ~a;
            end
            OP_XOR: begin
              res_ld = 1'b1;
              res_f  = a ^ b;
            end
            OP_OR: begin
              res_ld = 1'b1;
              res_f  = a | b;
            end
            OP_AND: begin
              res_ld = 1'b1;
              res_f  = a & b;
            end
            default: res_ld = 1'b0;
          endcase
        end
      end
      S_MUL: begin
        if (last_iter) begin
          res_ld = 1'b1;
          res_f  = acc_nx[DATA_WIDTH-1:0];
`ifdef SEQ_ALU_FLAGS_EN
          res_c  = |acc_nx[2*DATA_WIDTH-1:DATA_WIDTH];
`endif
        end
      end
      S_DIV: begin
        if (last_iter) begin
          res_ld  = 1'b1;
          res_f   = quot_nx;
          res_rem = part_nx;
        end
      end
      default: res_ld = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      opa_r  <= a;
      opb_r  <= b;
      acc_r  <= {{DATA_WIDTH{1'b0}}, b};
      part_r <= '0;
      quot_r <= a;
    end else if (state == S_MUL) begin
      acc_r  <= acc_nx;
    end else if (state == S_DIV) begin
      part_r <= part_nx;
      quot_r <= quot_nx;
    end
  end

  // Control and architectural outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      f        <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
      flags_r  <= 4'b0000;
`endif
    end else begin
      state <= state_nx;
      if (accept)
        cnt <= '0;
      else if (state == S_MUL || state == S_DIV)
        cnt <= cnt + CNT_WIDTH'(1);
      if (res_ld) begin
        f        <= res_f;
        rem      <= res_rem;
        div_zero <= res_dz;
`ifdef SEQ_ALU_FLAGS_EN
        flags_r  <= pack_flags(res_f, res_c, res_v);
`endif
      end
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  assign flags = flags_r;
`else
  assign flags = 4'b0000;
`endif

endmodule
